// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the SPARC V8 datapath. Owns PC/nPC and reads the word at PC
// over a RAM handshake that ends with MFC. The word is presented to the
// control unit as IR_Out/ir_valid and held until ir_ack. PC/nPC then advance
// with delayed-branch semantics: the delay slot at the old nPC always issues
// next, and redirect only replaces the nPC that follows it. An annul request
// fetches the delay-slot word and discards it. Misaligned PCs and MFC
// timeouts park the unit in FAULT until fault_clr.
//
// Build option:
//   FETCH_PERF_CNT_EN - adds retired_cnt / annulled_cnt performance counters.
//
// Ports:
//   Clk, RESET           clock (rising edge); async active-high reset
//   run                  fetch enable, sampled at instruction boundaries
//   mem_addr/rd/opcode   RAM request (address = PC, load-word opcode)
//   mem_data, MFC        RAM response; data is valid while MFC=1
//   IR_Out, ir_valid     instruction presented to the control unit
//   ir_ack               control unit finished IR
//   redirect(_npc)       new nPC, sampled with ir_ack
//   annul                discard the delay-slot word, sampled with ir_ack
//   pc_out, npc_out      registered PC / nPC
//   fault, fault_tt      fault pending; 001 misaligned, 010 MFC timeout
//   fault_clr            leave FAULT for IDLE
//   retired_cnt          (FETCH_PERF_CNT_EN) count of accepted ir_acks
//   annulled_cnt         (FETCH_PERF_CNT_EN) count of discarded fetches
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16,
   // 2**CNT_W must exceed TIMEOUT_CYCLES so the count can reach the limit
   parameter int          CNT_W          = 5
) (
   input  logic        Clk,
   input  logic        RESET,
   input  logic        run,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic [5:0]  mem_opcode,
   input  logic [31:0] mem_data,
   input  logic        MFC,
   output logic [31:0] IR_Out,
   output logic        ir_valid,
   input  logic        ir_ack,
   input  logic        redirect,
   input  logic [31:0] redirect_npc,
   input  logic        annul,
   output logic [31:0] pc_out,
   output logic [31:0] npc_out,
   output logic        fault,
   output logic [2:0]  fault_tt,
   input  logic        fault_clr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [15:0] annulled_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WAIT  = 3'd2,
      ISSUE = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam logic [2:0]       TT_NONE     = 3'b000;
   localparam logic [2:0]       TT_MISALIGN = 3'b001;
   localparam logic [2:0]       TT_TIMEOUT  = 3'b010;
   localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state, state_nxt;
   logic [31:0]      pc, pc_nxt;
   logic [31:0]      npc, npc_nxt;
   logic [31:0]      ir, ir_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             annul_q, annul_nxt;
   logic [2:0]       tt, tt_nxt;

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         npc     <= RESET_PC + 32'd4;
         ir      <= '0;
         cnt     <= '0;
         annul_q <= 1'b0;
         tt      <= TT_NONE;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         npc     <= npc_nxt;
         ir      <= ir_nxt;
         cnt     <= cnt_nxt;
         annul_q <= annul_nxt;
         tt      <= tt_nxt;
      end
   end

   assign cnt_inc = cnt + CNT_ONE;

   // -------------------------------------------------------------------------
   // Next state / request strobe
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      npc_nxt   = npc;
      ir_nxt    = ir;
      cnt_nxt   = cnt;
      annul_nxt = annul_q;
      tt_nxt    = tt;
      mem_rd    = 1'b0;

      case (state)
         IDLE: begin
            if (run) state_nxt = ADDR;
         end

         ADDR: begin
            // A misaligned PC never reaches the RAM: no read strobe at all.
            if (pc[1:0] != 2'b00) begin
               tt_nxt    = TT_MISALIGN;
               state_nxt = FAULT;
            end else begin
               mem_rd    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = WAIT;
            end
         end

         WAIT: begin
            mem_rd  = 1'b1;
            cnt_nxt = cnt_inc;
            // MFC is tested first so it wins over a timeout on the same cycle.
            if (MFC) begin
               ir_nxt = mem_data;
               if (annul_q) begin
                  // Annulled delay slot: consume the word silently and step
                  // straight on to the branch target already sitting in nPC.
                  annul_nxt = 1'b0;
                  pc_nxt    = npc;
                  npc_nxt   = npc + 32'd4;
                  state_nxt = ADDR;
               end else begin
                  state_nxt = ISSUE;
               end
            end else if (cnt_inc == CNT_LIMIT) begin
               tt_nxt    = TT_TIMEOUT;
               state_nxt = FAULT;
            end
         end

         ISSUE: begin
            if (ir_ack) begin
               // Delayed branch: the old nPC (delay slot) is always next;
               // redirect only chooses what follows it.
               pc_nxt    = npc;
               npc_nxt   = redirect ? redirect_npc : npc + 32'd4;
               annul_nxt = annul;
               state_nxt = run ? ADDR : IDLE;
            end
         end

         FAULT: begin
            // PC/nPC stay frozen at the faulting values for the handler.
            if (fault_clr) begin
               tt_nxt    = TT_NONE;
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs. Everything is decoded from registered state, so an async RESET
   // drops mem_rd and ir_valid immediately.
   // -------------------------------------------------------------------------
   assign mem_addr   = pc;
   assign mem_opcode = 6'b000000;
   assign IR_Out     = ir;
   assign ir_valid   = (state == ISSUE);
   assign pc_out     = pc;
   assign npc_out    = npc;
   assign fault      = (state == FAULT);
   assign fault_tt   = tt;

`ifdef FETCH_PERF_CNT_EN
   logic retire, discard;

   assign retire  = (state == ISSUE) && ir_ack;
   assign discard = (state == WAIT) && MFC && annul_q;

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         retired_cnt  <= '0;
         annulled_cnt <= '0;
      end else begin
         if (retire)  retired_cnt  <= retired_cnt + 32'd1;
         if (discard) annulled_cnt <= annulled_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. A small RAM responder drives MFC
// one cycle after the request appears; expected PC/nPC/IR values are hand
// computed from the delayed-branch rules. Inputs are driven and outputs are
// sampled on the falling edge of Clk.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   logic        Clk = 1'b0;
   logic        RESET, run, MFC, ir_ack, redirect, annul, fault_clr;
   logic [31:0] mem_data, redirect_npc;
   logic [31:0] mem_addr, IR_Out, pc_out, npc_out;
   logic        mem_rd, ir_valid, fault;
   logic [5:0]  mem_opcode;
   logic [2:0]  fault_tt;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [15:0] annulled_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   instruction_fetch_unit dut (
      .Clk          (Clk),
      .RESET        (RESET),
      .run          (run),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_opcode   (mem_opcode),
      .mem_data     (mem_data),
      .MFC          (MFC),
      .IR_Out       (IR_Out),
      .ir_valid     (ir_valid),
      .ir_ack       (ir_ack),
      .redirect     (redirect),
      .redirect_npc (redirect_npc),
      .annul        (annul),
      .pc_out       (pc_out),
      .npc_out      (npc_out),
      .fault        (fault),
      .fault_tt     (fault_tt),
      .fault_clr    (fault_clr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .retired_cnt  (retired_cnt),
      .annulled_cnt (annulled_cnt)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // Wait (bounded) for the read strobe, check the address, then answer with
   // MFC one cycle later. Returns on the negedge after the MFC cycle.
   task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
      int i = 0;
      while (!mem_rd && i < 40) begin
         @(negedge Clk);
         i++;
      end
      chk({tag, "_rd"}, mem_rd, 32'd1);
      chk({tag, "_addr"}, mem_addr, addr);
      @(negedge Clk);
      MFC = 1'b1; mem_data = data;
      @(negedge Clk);
      MFC = 1'b0; mem_data = 32'hDEAD_BEEF;
   endtask

   // Check the issued instruction and PC/nPC, then acknowledge it.
   task automatic issue(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] npc, input logic rdr, input logic [31:0] rnpc,
                        input logic ann);
      chk({tag, "_vld"}, ir_valid, 32'd1);
      chk({tag, "_ir"}, IR_Out, ir);
      chk({tag, "_pc"}, pc_out, pc);
      chk({tag, "_npc"}, npc_out, npc);
      ir_ack = 1'b1; redirect = rdr; redirect_npc = rnpc; annul = ann;
      @(negedge Clk);
      ir_ack = 1'b0; redirect = 1'b0; annul = 1'b0;
      chk({tag, "_drop"}, ir_valid, 32'd0);
   endtask

   initial begin
      logic rd_seen;
      RESET = 1'b1; run = 1'b0; MFC = 1'b0; ir_ack = 1'b0; redirect = 1'b0;
      annul = 1'b0; fault_clr = 1'b0; mem_data = '0; redirect_npc = '0;

      // Reset state
      repeat (2) @(negedge Clk);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_npc", npc_out, 32'h4);
      chk("rst_ir", IR_Out, 32'h0);
      chk("rst_vld", ir_valid, 32'd0);
      chk("rst_rd", mem_rd, 32'd0);
      chk("rst_fault", fault, 32'd0);
      chk("rst_tt", fault_tt, 32'd0);
      chk("opcode", mem_opcode, 32'd0);
      RESET = 1'b0;
      @(negedge Clk);
      run = 1'b1;

      // Sequential fetch
      serve("f0", 32'h0, 32'h8200_0001);
      issue("f0", 32'h8200_0001, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0);
      serve("f1", 32'h4, 32'h8400_0002);
      // IR holds while waiting for ack; a stray MFC outside WAIT is ignored
      MFC = 1'b1; mem_data = 32'h1234_5678;
      @(negedge Clk);
      MFC = 1'b0;
      chk("hold_ir", IR_Out, 32'h8400_0002);
      chk("hold_vld", ir_valid, 32'd1);
      issue("f1", 32'h8400_0002, 32'h4, 32'h8, 1'b0, 32'h0, 1'b0);

      // Branch redirect at PC=8: delay slot at 0xC, then target 0x40
      serve("f2", 32'h8, 32'h8600_0003);
      issue("f2", 32'h8600_0003, 32'h8, 32'hC, 1'b1, 32'h40, 1'b0);
      serve("ds", 32'hC, 32'h8800_0004);
      issue("ds", 32'h8800_0004, 32'hC, 32'h40, 1'b0, 32'h0, 1'b0);
      serve("tg", 32'h40, 32'h8A00_0005);
      issue("tg", 32'h8A00_0005, 32'h40, 32'h44, 1'b1, 32'h10, 1'b0);
      serve("f5", 32'h44, 32'h8C00_0006);
      issue("f5", 32'h8C00_0006, 32'h44, 32'h10, 1'b0, 32'h0, 1'b0);

      // Annul: delay slot at 0x14 fetched but never issued
      serve("f6", 32'h10, 32'h8E00_0007);
      issue("f6", 32'h8E00_0007, 32'h10, 32'h14, 1'b1, 32'h80, 1'b1);
      serve("an", 32'h14, 32'h9000_0008);
      chk("an_vld", ir_valid, 32'd0);
      chk("an_pc", pc_out, 32'h80);
      chk("an_npc", npc_out, 32'h84);
      serve("f8", 32'h80, 32'h9200_0009);
      issue("f8", 32'h9200_0009, 32'h80, 32'h84, 1'b1, 32'h22, 1'b0);
      serve("f9", 32'h84, 32'h9400_000A);
      issue("f9", 32'h9400_000A, 32'h84, 32'h22, 1'b0, 32'h0, 1'b0);

      // Misaligned fetch at 0x22: no read strobe, tt=001
      rd_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_rd) rd_seen = 1'b1;
         if (fault) break;
         @(negedge Clk);
      end
      chk("mis_rd_seen", rd_seen, 32'd0);
      chk("mis_fault", fault, 32'd1);
      chk("mis_tt", fault_tt, 32'd1);
      chk("mis_pc", pc_out, 32'h22);
      chk("mis_npc", npc_out, 32'h26);
      chk("mis_vld", ir_valid, 32'd0);
      run = 1'b0; fault_clr = 1'b1;
      @(negedge Clk);
      fault_clr = 1'b0;
      chk("mis_clr_fault", fault, 32'd0);
      chk("mis_clr_tt", fault_tt, 32'd0);

      // Timeout: 16 WAIT cycles without MFC
      RESET = 1'b1;
      @(negedge Clk);
      RESET = 1'b0;
      run = 1'b1;
      for (int i = 0; i < 40 && !mem_rd; i++) @(negedge Clk);
      chk("to_addr", mem_addr, 32'h0);
      repeat (16) @(negedge Clk);
      chk("to_last_wait_fault", fault, 32'd0);
      chk("to_last_wait_rd", mem_rd, 32'd1);
      @(negedge Clk);
      chk("to_fault", fault, 32'd1);
      chk("to_tt", fault_tt, 32'd2);
      chk("to_rd", mem_rd, 32'd0);
      chk("to_pc", pc_out, 32'h0);
      run = 1'b0; fault_clr = 1'b1;
      @(negedge Clk);
      fault_clr = 1'b0;
      chk("to_clr_fault", fault, 32'd0);
      chk("to_clr_tt", fault_tt, 32'd0);
      chk("to_clr_rd", mem_rd, 32'd0);

      // Reset in the middle of WAIT
      run = 1'b1;
      serve("r0", 32'h0, 32'hA000_0001);
      issue("r0", 32'hA000_0001, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0);
      @(negedge Clk);
      chk("rw_rd", mem_rd, 32'd1);
      chk("rw_addr", mem_addr, 32'h4);
      RESET = 1'b1;
      #1;
      chk("rw_async_rd", mem_rd, 32'd0);
      chk("rw_async_pc", pc_out, 32'h0);
      chk("rw_async_npc", npc_out, 32'h4);
      chk("rw_async_vld", ir_valid, 32'd0);
      run = 1'b0;
      @(negedge Clk);
      RESET = 1'b0; MFC = 1'b1; mem_data = 32'h5555_AAAA;
      @(negedge Clk);
      MFC = 1'b0;
      chk("rw_late_vld", ir_valid, 32'd0);
      chk("rw_late_ir", IR_Out, 32'h0);
      chk("rw_late_rd", mem_rd, 32'd0);

      // nPC wraps: 0xFFFF_FFFC + 4 = 0
      run = 1'b1;
      serve("w0", 32'h0, 32'hB000_0001);
      issue("w0", 32'hB000_0001, 32'h0, 32'h4, 1'b1, 32'hFFFF_FFFC, 1'b0);
      serve("w1", 32'h4, 32'hB000_0002);
      issue("w1", 32'hB000_0002, 32'h4, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
      serve("w2", 32'hFFFF_FFFC, 32'hB000_0003);
      issue("w2", 32'hB000_0003, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("w_pc", pc_out, 32'h0);
      chk("w_npc", npc_out, 32'h4);
      run = 1'b0;
      repeat (2) @(negedge Clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage of the SPARC V8 datapath. Owns PC/nPC, reads the instruction word at PC from instruction memory (RAM handshake terminated by MFC), and presents it as IR to the control unit. It holds IR stable until the control unit acknowledges completion, then advances PC/nPC using SPARC delayed-branch semantics. It applies branch redirects and annul requests from the control unit, and flags misaligned or timed-out fetches as faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC resets to RESET_PC+4.
TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT for MFC before a fetch fault.
CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
Clk  in  1  rising-edge clock
RESET  in  1  reset RESET, asynchronous, active-high
run  in  1  fetch enable; when low, the FSM stays in or returns to IDLE at the next instruction boundary
mem_addr  out  32  fetch address, equal to PC
mem_rd  out  1  read strobe, held high from ADDR through end of WAIT
mem_opcode  out  6  RAM opcode, constant 6'b000000 (load word)
mem_data  in  32  instruction word, valid while MFC=1
MFC  in  1  memory function complete
IR_Out  out  32  instruction register
ir_valid  out  1  IR holds a new instruction for the control unit
ir_ack  in  1  control unit finished executing IR
redirect  in  1  sampled with ir_ack; load redirect_npc as the new nPC
redirect_npc  in  32  branch/call/jmpl target
annul  in  1  sampled with ir_ack; discard the next sequential (delay-slot) instruction
pc_out  out  32  current PC
npc_out  out  32  current nPC
fault  out  1  fetch fault pending
fault_tt  out  3  3'b001 = misaligned PC, 3'b010 = MFC timeout
fault_clr  in  1  clears the fault and returns to IDLE

Behaviour:
- Reset state: PC=RESET_PC, nPC=RESET_PC+4, IR_Out=0, ir_valid=0, mem_rd=0, fault=0, fault_tt=0, state=IDLE, timeout counter=0. RESET mid-fetch aborts at once; mem_rd drops asynchronously.
- States: IDLE, ADDR, WAIT, ISSUE, FAULT.
- IDLE: if run=1, go to ADDR.
- ADDR: if PC[1:0]≠0, go to FAULT with tt=001 and never assert mem_rd. Otherwise assert mem_rd, clear the counter, and go to WAIT.
- WAIT: mem_rd=1; the counter increments every cycle.
  - On MFC=1: latch mem_data into IR_Out, drop mem_rd. If the annul flag is set, clear it, advance PC/nPC, and go to ADDR without asserting ir_valid. Otherwise set ir_valid=1 and go to ISSUE.
  - If the counter reaches TIMEOUT_CYCLES with MFC=0: go to FAULT with tt=010.
  - MFC and timeout on the same cycle: MFC wins.
- ISSUE: IR_Out is held constant and ir_valid=1 until ir_ack=1. On ir_ack:
  - ir_valid drops the next cycle.
  - PC<=nPC.
  - nPC<=redirect ? redirect_npc : nPC+4.
  - annul flag<=annul.
  - Next state is ADDR if run=1, else IDLE.
  - Minimum fetch-to-issue latency: 3 cycles after entering ADDR with 1-cycle MFC (ADDR, WAIT, IR latched).
- FAULT: fault=1, fault_tt held, mem_rd=0, ir_valid=0. PC/nPC are frozen at the faulting values. fault_clr → IDLE with fault=0 and tt=0. RESET takes priority over fault_clr.
- Arithmetic: 32-bit, wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- MFC outside WAIT is ignored. ir_ack outside ISSUE is ignored.
- pc_out and npc_out are always the registered values.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds output retired_cnt[31:0] and output annulled_cnt[15:0]. retired_cnt increments on each ir_ack accepted in ISSUE. annulled_cnt increments on each discarded fetch. Both are cleared by RESET and both wrap. When undefined, neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Sequential fetch: reset, run=1, MFC one cycle after mem_rd with data 0x8200_0001/0x8400_0002, ack each → IR_Out sequence matches; PC 0→4→8; nPC 4→8→C.
- Branch redirect: at PC=8, ack with redirect=1, redirect_npc=0x40 → next fetch at 0xC (delay slot), then 0x40; nPC=0x44.
- Annul: ack at PC=0x10 with redirect=1, redirect_npc=0x80, annul=1 → word at 0x14 fetched, ir_valid never asserted for it; next issued IR from 0x80.
- Timeout: MFC held 0 for 16 cycles in WAIT → fault=1, tt=010, mem_rd=0, PC unchanged; fault_clr → IDLE, fault=0.
- Misaligned: redirect_npc=0x22 → fetch at 0x22 faults with tt=001 and no mem_rd pulse.
- Reset mid-WAIT: assert RESET while mem_rd=1 → mem_rd=0 immediately, PC=RESET_PC, ir_valid=0; a late MFC pulse is ignored.
